// File: rtl/jtframe_ioctl_packer.sv
// Packs the ioctl byte stream into 16-bit SDRAM word writes with byte enables,
// diverting bytes in the PROM window to a one-cycle PROM write port.
module jtframe_ioctl_packer #(
    parameter int              AW         = 22,
    parameter logic [AW-1:0]   PROM_START = 22'h3FFF00,
    parameter int              PROMW      = 8,
    parameter int              FIFO_DEPTH = 4,
    parameter int              SWAP       = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             downloading,
    input  logic [AW-1:0]    ioctl_addr,
    input  logic [7:0]       ioctl_data,
    input  logic             ioctl_wr,
    output logic [AW-2:0]    prog_addr,
    output logic [15:0]      prog_data,
    output logic [1:0]       prog_be,
    output logic             prog_we,
    input  logic             prog_rdy,
    output logic [PROMW-1:0] prom_addr,
    output logic [7:0]       prom_data,
    output logic             prom_we,
    output logic             dwnld_busy,
    output logic             overrun
);
    localparam int         PW         = $clog2(FIFO_DEPTH);
    localparam bit         SWAP_LANES = (SWAP != 0);
    localparam logic [1:0] EVEN_BE    = SWAP_LANES ? 2'b10 : 2'b01;
    localparam logic [1:0] ODD_BE     = SWAP_LANES ? 2'b01 : 2'b10;

    typedef enum logic [1:0] {IDLE, HALF, WRITE} state_t;

    state_t        state;
    logic [AW-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]    fifo_data [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic [AW-1:0] head_addr;
    logic [7:0]    head_data;
    logic          head_pair;
    logic [AW-2:0] held_word;
    logic [7:0]    held_data;
    logic          dl_prev;

    function automatic logic [15:0] lane_word(input logic [7:0] b, input logic odd);
        lane_word = (odd ^ SWAP_LANES) ? {b, 8'h00} : {8'h00, b};
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == (PW+1)'(FIFO_DEPTH));
    assign head_addr = fifo_addr[rd_ptr];
    assign head_data = fifo_data[rd_ptr];
    // Only the odd partner of the held even byte, outside the PROM window, completes a pair.
    assign head_pair = (head_addr == {held_word, 1'b1}) && (head_addr < PROM_START);
    assign push      = ioctl_wr && (!full || pop);

    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:    pop = !empty;
            HALF:    pop = !empty && head_pair;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= ioctl_addr;
            fifo_data[wr_ptr] <= ioctl_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overrun    <= 1'b0;
            dl_prev    <= 1'b0;
            dwnld_busy <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count   <= count + (PW+1)'(push) - (PW+1)'(pop);
            dl_prev <= downloading;
            // A drop in the same cycle as a new download start still gets reported.
            if (ioctl_wr && !push)
                overrun <= 1'b1;
            else if (downloading && !dl_prev)
                overrun <= 1'b0;
            if (downloading)
                dwnld_busy <= 1'b1;
            else if (empty && state == IDLE)
                dwnld_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prog_addr <= '0;
            prog_data <= '0;
            prog_be   <= '0;
            prog_we   <= 1'b0;
            prom_addr <= '0;
            prom_data <= '0;
            prom_we   <= 1'b0;
            held_word <= '0;
            held_data <= '0;
        end else begin
            prom_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        if (head_addr >= PROM_START) begin
                            prom_we   <= 1'b1;
                            prom_addr <= head_addr[PROMW-1:0];
                            prom_data <= head_data;
                        end else if (head_addr[0]) begin
                            prog_addr <= head_addr[AW-1:1];
                            prog_data <= lane_word(head_data, 1'b1);
                            prog_be   <= ODD_BE;
                            prog_we   <= 1'b1;
                            state     <= WRITE;
                        end else begin
                            held_word <= head_addr[AW-1:1];
                            held_data <= head_data;
                            state     <= HALF;
                        end
                    end
                end
                HALF: begin
                    if (!empty && head_pair) begin
                        prog_addr <= held_word;
                        prog_data <= lane_word(held_data, 1'b0) | lane_word(head_data, 1'b1);
                        prog_be   <= 2'b11;
                        prog_we   <= 1'b1;
                        state     <= WRITE;
                    end else if (!empty || !downloading) begin
                        // Unrelated head or end of download: the even byte goes out alone.
                        prog_addr <= held_word;
                        prog_data <= lane_word(held_data, 1'b0);
                        prog_be   <= EVEN_BE;
                        prog_we   <= 1'b1;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (prog_rdy) begin
                        prog_we <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtframe_ioctl_packer.sv
// Bench for jtframe_ioctl_packer: SWAP=0 and SWAP=1 instances share all inputs;
// expected SDRAM/PROM writes go into queues and are matched as the DUTs commit them.
module tb_jtframe_ioctl_packer;
    logic        clk;
    logic        rst_n;
    logic        downloading;
    logic [21:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic        prog_rdy;

    logic [20:0] prog_addr_s0, prog_addr_s1;
    logic [15:0] prog_data_s0, prog_data_s1;
    logic [1:0]  prog_be_s0, prog_be_s1;
    logic        prog_we_s0, prog_we_s1;
    logic [7:0]  prom_addr_s0, prom_addr_s1;
    logic [7:0]  prom_data_s0, prom_data_s1;
    logic        prom_we_s0, prom_we_s1;
    logic        busy_s0, busy_s1;
    logic        overrun_s0, overrun_s1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [38:0] exp_q0[$];
    logic [38:0] exp_q1[$];
    logic [15:0] prom_q0[$];
    logic [15:0] prom_q1[$];

    logic        prev_hold0 = 1'b0;
    logic [39:0] prev_word0 = '0;

    typedef struct {
        logic [21:0] addr;
        logic [7:0]  data;
        logic        pv;
        logic [20:0] pa;
        logic [15:0] pd;
        logic [1:0]  pbe;
        logic        mv;
        logic [7:0]  ma;
        logic [7:0]  md;
    } vec_t;
    vec_t vec[15];

    jtframe_ioctl_packer #(.SWAP(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(prog_addr_s0), .prog_data(prog_data_s0), .prog_be(prog_be_s0),
        .prog_we(prog_we_s0), .prog_rdy(prog_rdy),
        .prom_addr(prom_addr_s0), .prom_data(prom_data_s0), .prom_we(prom_we_s0),
        .dwnld_busy(busy_s0), .overrun(overrun_s0)
    );

    jtframe_ioctl_packer #(.SWAP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(prog_addr_s1), .prog_data(prog_data_s1), .prog_be(prog_be_s1),
        .prog_we(prog_we_s1), .prog_rdy(prog_rdy),
        .prom_addr(prom_addr_s1), .prom_data(prom_data_s1), .prom_we(prom_we_s1),
        .dwnld_busy(busy_s1), .overrun(overrun_s1)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [21:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        @(posedge clk);
        #1;
        ioctl_wr   = 1'b0;
    endtask

    task automatic exp_prog(input logic [20:0] a, input logic [15:0] d, input logic [1:0] be);
        exp_q0.push_back({a, d, be});
        exp_q1.push_back({a, d[7:0], d[15:8], be[0], be[1]});
    endtask

    task automatic exp_prom(input logic [7:0] a, input logic [7:0] d);
        prom_q0.push_back({a, d});
        prom_q1.push_back({a, d});
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy_s0 !== 1'b0 && n < 100) begin
            tick(1);
            n++;
        end
        check(name, {63'd0, busy_s0}, 64'd0);
        check({name, "_drained"},
              64'(exp_q0.size() + exp_q1.size() + prom_q0.size() + prom_q1.size()), 64'd0);
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_hold0)
                check("prog0_stable", {24'd0, prog_we_s0, prog_addr_s0, prog_data_s0, prog_be_s0},
                      {24'd0, prev_word0});
            prev_hold0 = prog_we_s0 && !prog_rdy;
            prev_word0 = {prog_we_s0, prog_addr_s0, prog_data_s0, prog_be_s0};
            if (prog_we_s0 && prog_rdy) begin
                if (exp_q0.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL prog0_unexpected: got %0h expected no write",
                             {prog_addr_s0, prog_data_s0, prog_be_s0});
                end else
                    check("prog0", 64'({prog_addr_s0, prog_data_s0, prog_be_s0}), 64'(exp_q0.pop_front()));
            end
            if (prog_we_s1 && prog_rdy) begin
                if (exp_q1.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL prog1_unexpected: got %0h expected no write",
                             {prog_addr_s1, prog_data_s1, prog_be_s1});
                end else
                    check("prog1", 64'({prog_addr_s1, prog_data_s1, prog_be_s1}), 64'(exp_q1.pop_front()));
            end
            if (prom_we_s0) begin
                if (prom_q0.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL prom0_unexpected: got %0h expected no write", {prom_addr_s0, prom_data_s0});
                end else
                    check("prom0", 64'({prom_addr_s0, prom_data_s0}), 64'(prom_q0.pop_front()));
            end
            if (prom_we_s1) begin
                if (prom_q1.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL prom1_unexpected: got %0h expected no write", {prom_addr_s1, prom_data_s1});
                end else
                    check("prom1", 64'({prom_addr_s1, prom_data_s1}), 64'(prom_q1.pop_front()));
            end
        end else begin
            prev_hold0 = 1'b0;
        end
    end

    initial begin
        vec[0]  = '{22'h000000, 8'h12, 1'b0, 21'h0,      16'h0000, 2'b00, 1'b0, 8'h00, 8'h00};
        vec[1]  = '{22'h000001, 8'h34, 1'b1, 21'h0,      16'h3412, 2'b11, 1'b0, 8'h00, 8'h00};
        vec[2]  = '{22'h000010, 8'hAB, 1'b0, 21'h0,      16'h0000, 2'b00, 1'b0, 8'h00, 8'h00};
        vec[3]  = '{22'h000020, 8'hCD, 1'b1, 21'h8,      16'h00AB, 2'b01, 1'b0, 8'h00, 8'h00};
        vec[4]  = '{22'h3FFF03, 8'h5A, 1'b1, 21'h10,     16'h00CD, 2'b01, 1'b1, 8'h03, 8'h5A};
        vec[5]  = '{22'h000033, 8'h77, 1'b1, 21'h19,     16'h7700, 2'b10, 1'b0, 8'h00, 8'h00};
        vec[6]  = '{22'h3FFFFF, 8'hEE, 1'b0, 21'h0,      16'h0000, 2'b00, 1'b1, 8'hFF, 8'hEE};
        vec[7]  = '{22'h3FFEFF, 8'h99, 1'b1, 21'h1FFF7F, 16'h9900, 2'b10, 1'b0, 8'h00, 8'h00};
        vec[8]  = '{22'h3FFF00, 8'h42, 1'b0, 21'h0,      16'h0000, 2'b00, 1'b1, 8'h00, 8'h42};
        vec[9]  = '{22'h000044, 8'h55, 1'b0, 21'h0,      16'h0000, 2'b00, 1'b0, 8'h00, 8'h00};
        vec[10] = '{22'h000046, 8'h66, 1'b1, 21'h22,     16'h0055, 2'b01, 1'b0, 8'h00, 8'h00};
        vec[11] = '{22'h000047, 8'h88, 1'b1, 21'h23,     16'h8866, 2'b11, 1'b0, 8'h00, 8'h00};
        vec[12] = '{22'h3FFEFE, 8'h10, 1'b0, 21'h0,      16'h0000, 2'b00, 1'b0, 8'h00, 8'h00};
        vec[13] = '{22'h3FFEFF, 8'h20, 1'b1, 21'h1FFF7F, 16'h2010, 2'b11, 1'b0, 8'h00, 8'h00};
        vec[14] = '{22'h000050, 8'h9C, 1'b0, 21'h0,      16'h0000, 2'b00, 1'b0, 8'h00, 8'h00};

        rst_n = 1'b1; downloading = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_data = '0; prog_rdy = 1'b1;
        #2 rst_n = 1'b0;
        tick(3);
        check("reset_s0", 64'({prog_addr_s0, prog_data_s0, prog_be_s0, prog_we_s0, prom_addr_s0,
                               prom_data_s0, prom_we_s0, busy_s0, overrun_s0}), 64'd0);
        check("reset_s1", 64'({prog_addr_s1, prog_data_s1, prog_be_s1, prog_we_s1, prom_addr_s1,
                               prom_data_s1, prom_we_s1, busy_s1, overrun_s1}), 64'd0);
        rst_n = 1'b1;
        tick(2);

        downloading = 1'b1;
        @(negedge clk); check("busy_before_edge", {63'd0, busy_s0}, 64'd0);
        @(negedge clk); check("busy_set", {63'd0, busy_s0}, 64'd1);
        tick(1);

        // table-driven pairing, lone bytes and PROM routing
        for (int i = 0; i < 15; i++) begin
            if (vec[i].pv) exp_prog(vec[i].pa, vec[i].pd, vec[i].pbe);
            if (vec[i].mv) exp_prom(vec[i].ma, vec[i].md);
            strobe(vec[i].addr, vec[i].data);
            tick($urandom_range(2, 3));
        end
        exp_prog(21'h28, 16'h009C, 2'b01);
        downloading = 1'b0;
        @(negedge clk); check("busy_held_after_fall", {63'd0, busy_s0}, 64'd1);
        tick(1);
        wait_idle("busy_clear_table");

        // latency of a completing odd byte and of a PROM byte
        downloading = 1'b1;
        tick(2);
        exp_prog(21'h30, 16'hBBAA, 2'b11);
        strobe(22'h000060, 8'hAA);
        strobe(22'h000061, 8'hBB);
        @(negedge clk); check("pair_lat_early", {63'd0, prog_we_s0}, 64'd0);
        @(negedge clk); check("pair_lat", {63'd0, prog_we_s0}, 64'd1);
        tick(1);
        exp_prom(8'h7F, 8'hC3);
        strobe(22'h3FFF7F, 8'hC3);
        @(negedge clk); check("prom_lat_early", {63'd0, prom_we_s0, prog_we_s0}, 64'd0);
        @(negedge clk); check("prom_lat", {63'd0, prom_we_s0, prog_we_s0}, 64'd2);
        @(negedge clk); check("prom_pulse_end", {63'd0, prom_we_s0}, 64'd0);
        tick(2);

        // backpressure: write stalled, FIFO fills, last two strobes dropped
        prog_rdy = 1'b0;
        exp_prog(21'h20, 16'h0201, 2'b11);
        exp_prog(21'h21, 16'h0403, 2'b11);
        exp_prog(21'h22, 16'h0605, 2'b11);
        strobe(22'h000040, 8'h01);
        strobe(22'h000041, 8'h02);
        for (int i = 0; i < 6; i++) strobe(22'h000042 + 22'(i), 8'h03 + 8'(i));
        tick(10);
        @(negedge clk);
        check("stall_state", {61'd0, prog_we_s0, overrun_s0, overrun_s1}, 64'h7);
        tick(1);
        prog_rdy = 1'b1;
        downloading = 1'b0;
        wait_idle("busy_clear_backpressure");
        check("overrun_sticky", {62'd0, overrun_s0, overrun_s1}, 64'h3);
        downloading = 1'b1;
        @(negedge clk); check("overrun_before_rise", {63'd0, overrun_s0}, 64'd1);
        @(negedge clk); check("overrun_cleared", {62'd0, overrun_s0, overrun_s1}, 64'd0);
        tick(1);

        // asynchronous reset while a write is stalled
        prog_rdy = 1'b0;
        strobe(22'h000070, 8'h11);
        strobe(22'h000071, 8'h22);
        for (int i = 0; i < 6; i++) strobe(22'h000072 + 22'(i), 8'(i));
        @(negedge clk);
        check("pre_reset", {61'd0, prog_we_s0, busy_s0, overrun_s0}, 64'h7);
        tick(1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_s0", {61'd0, prog_we_s0, busy_s0, overrun_s0}, 64'd0);
        check("async_reset_s1", {61'd0, prog_we_s1, busy_s1, overrun_s1}, 64'd0);
        downloading = 1'b0;
        tick(2);
        rst_n = 1'b1;
        prog_rdy = 1'b1;
        tick(2);
        downloading = 1'b1;
        tick(2);
        exp_prog(21'h38, 16'hE1D0, 2'b11);
        strobe(22'h000070, 8'hD0);
        strobe(22'h000071, 8'hE1);
        tick(2);
        downloading = 1'b0;
        wait_idle("busy_clear_after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
